// File: rtl/ex_issue_ctrl_if.sv
// Decode-to-execute bundle: decoded instruction fields offered by ID and the
// registered copy, valid/ready handshake and forwarding selects seen by EX.
interface ex_issue_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5
);
    logic                  id_valid_i;
    logic                  id_ready_o;
    logic                  rs1_enable_i;
    logic                  rs2_enable_i;
    logic [REG_ADDR_W-1:0] rs1_addr_i;
    logic [REG_ADDR_W-1:0] rs2_addr_i;
    logic [REG_ADDR_W-1:0] rd_addr_i;
    logic                  rd_we_i;
    logic                  is_load_i;
    logic                  alu_2nd_src_i;
    logic                  jal_i;
    logic                  jalr_i;
    logic                  auipc_i;
    logic [DATA_WIDTH-1:0] pc_i;
    logic [DATA_WIDTH-1:0] imme_i;

    logic                  ex_valid_o;
    logic                  ex_ready_i;
    logic                  ex_rs1_enable_o;
    logic                  ex_rs2_enable_o;
    logic [REG_ADDR_W-1:0] ex_rs1_addr_o;
    logic [REG_ADDR_W-1:0] ex_rs2_addr_o;
    logic [REG_ADDR_W-1:0] ex_rd_addr_o;
    logic                  ex_rd_we_o;
    logic                  ex_is_load_o;
    logic                  ex_alu_2nd_src_o;
    logic                  ex_jal_o;
    logic                  ex_jalr_o;
    logic                  ex_auipc_o;
    logic [DATA_WIDTH-1:0] ex_pc_o;
    logic [DATA_WIDTH-1:0] ex_imme_o;
    logic [1:0]            fwd_a_o;
    logic [1:0]            fwd_b_o;

    // The issue controller sits on the slave side of this bundle.
    modport slave (
        input  id_valid_i, rs1_enable_i, rs2_enable_i, rs1_addr_i, rs2_addr_i,
               rd_addr_i, rd_we_i, is_load_i, alu_2nd_src_i, jal_i, jalr_i,
               auipc_i, pc_i, imme_i, ex_ready_i,
        output id_ready_o, ex_valid_o, ex_rs1_enable_o, ex_rs2_enable_o,
               ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o, ex_rd_we_o,
               ex_is_load_o, ex_alu_2nd_src_o, ex_jal_o, ex_jalr_o, ex_auipc_o,
               ex_pc_o, ex_imme_o, fwd_a_o, fwd_b_o
    );

    modport master (
        output id_valid_i, rs1_enable_i, rs2_enable_i, rs1_addr_i, rs2_addr_i,
               rd_addr_i, rd_we_i, is_load_i, alu_2nd_src_i, jal_i, jalr_i,
               auipc_i, pc_i, imme_i, ex_ready_i,
        input  id_ready_o, ex_valid_o, ex_rs1_enable_o, ex_rs2_enable_o,
               ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o, ex_rd_we_o,
               ex_is_load_o, ex_alu_2nd_src_o, ex_jal_o, ex_jalr_o, ex_auipc_o,
               ex_pc_o, ex_imme_o, fwd_a_o, fwd_b_o
    );
endinterface

// File: rtl/ex_issue_ctrl.sv
// ID/EX issue slot with load scoreboard (load-use and WAW stalls), operand
// forwarding selects, downstream backpressure, flush and a stall counter.
module ex_issue_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    ex_issue_ctrl_if.slave        bus,
    input  logic                  lsu_wb_valid_i,
    input  logic [REG_ADDR_W-1:0] lsu_wb_rd_i,
    input  logic                  flush_i,
    output logic [31:0]           stall_cnt_o
);
    localparam int NUM_REGS = 1 << REG_ADDR_W;

    typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_e;

    typedef struct packed {
        logic                  rs1_enable;
        logic                  rs2_enable;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic                  rd_we;
        logic                  is_load;
        logic                  alu_2nd_src;
        logic                  jal;
        logic                  jalr;
        logic                  auipc;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] imme;
    } payload_t;

    slot_e                state_q, state_d;
    payload_t             payload_q, payload_d;
    logic [1:0]           fwd_a_q, fwd_a_d;
    logic [1:0]           fwd_b_q, fwd_b_d;
    logic [NUM_REGS-1:0]  busy_q, busy_d;
    logic [31:0]          stall_cnt_q, stall_cnt_d;

    logic                 ex_valid;
    logic                 slot_frees;
    logic                 leaving;
    logic                 hazard;
    logic                 id_ready;
    logic                 accept;
    logic                 alu_fwd_ok;
    logic                 flush_load_drop;
    logic [NUM_REGS-1:0]  wb_hit;
    logic [NUM_REGS-1:0]  busy_eff;

    // Per-register view: a returning load hides its own busy bit this cycle.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
        assign wb_hit[gi] = lsu_wb_valid_i && (lsu_wb_rd_i == REG_ADDR_W'(gi));
        if (gi == 0) begin : g_zero
            assign busy_eff[gi] = 1'b0;
            assign busy_d[gi]   = 1'b0;
        end else begin : g_reg
            logic set_hit;
            logic clr_hit;
            assign busy_eff[gi] = busy_q[gi] && !wb_hit[gi];
            assign set_hit = accept && bus.is_load_i && bus.rd_we_i
                             && (bus.rd_addr_i == REG_ADDR_W'(gi));
            assign clr_hit = wb_hit[gi]
                             || (flush_load_drop && (payload_q.rd_addr == REG_ADDR_W'(gi)));
            assign busy_d[gi] = set_hit || (busy_q[gi] && !clr_hit);
        end
    end

    assign hazard = (bus.rs1_enable_i && busy_eff[bus.rs1_addr_i])
                 || (bus.rs2_enable_i && busy_eff[bus.rs2_addr_i])
                 || (bus.rd_we_i      && busy_eff[bus.rd_addr_i]);

    assign id_ready        = !flush_i && !hazard && slot_frees;
    assign accept          = bus.id_valid_i && id_ready;
    assign leaving         = ex_valid && bus.ex_ready_i;
    assign alu_fwd_ok      = leaving && payload_q.rd_we && !payload_q.is_load;
    assign flush_load_drop = flush_i && ex_valid && payload_q.is_load && payload_q.rd_we;

    // Slot state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot next state: flush dominates, then accept, then drain.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = SLOT_EMPTY;
        end else if (accept) begin
            state_d = SLOT_FULL;
        end else if (slot_frees) begin
            state_d = SLOT_EMPTY;
        end
    end

    // Slot outputs
    always_comb begin
        ex_valid   = 1'b0;
        slot_frees = 1'b1;
        case (state_q)
            SLOT_FULL: begin
                ex_valid   = 1'b1;
                slot_frees = bus.ex_ready_i;
            end
            default: begin
                ex_valid   = 1'b0;
                slot_frees = 1'b1;
            end
        endcase
    end

    // Payload and forwarding selects update only on accept.
    always_comb begin
        payload_d = payload_q;
        fwd_a_d   = fwd_a_q;
        fwd_b_d   = fwd_b_q;
        if (accept) begin
            payload_d.rs1_enable  = bus.rs1_enable_i;
            payload_d.rs2_enable  = bus.rs2_enable_i;
            payload_d.rs1_addr    = bus.rs1_addr_i;
            payload_d.rs2_addr    = bus.rs2_addr_i;
            payload_d.rd_addr     = bus.rd_addr_i;
            payload_d.rd_we       = bus.rd_we_i;
            payload_d.is_load     = bus.is_load_i;
            payload_d.alu_2nd_src = bus.alu_2nd_src_i;
            payload_d.jal         = bus.jal_i;
            payload_d.jalr        = bus.jalr_i;
            payload_d.auipc       = bus.auipc_i;
            payload_d.pc          = bus.pc_i;
            payload_d.imme        = bus.imme_i;

            fwd_a_d = 2'b00;
            if (bus.rs1_enable_i && (bus.rs1_addr_i != '0)) begin
                if (alu_fwd_ok && (payload_q.rd_addr == bus.rs1_addr_i)) begin
                    fwd_a_d = 2'b01;
                end else if (wb_hit[bus.rs1_addr_i]) begin
                    fwd_a_d = 2'b10;
                end
            end

            fwd_b_d = 2'b00;
            if (bus.rs2_enable_i && (bus.rs2_addr_i != '0)) begin
                if (alu_fwd_ok && (payload_q.rd_addr == bus.rs2_addr_i)) begin
                    fwd_b_d = 2'b01;
                end else if (wb_hit[bus.rs2_addr_i]) begin
                    fwd_b_d = 2'b10;
                end
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.id_valid_i && hazard && !flush_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            payload_q   <= '0;
            fwd_a_q     <= 2'b00;
            fwd_b_q     <= 2'b00;
            busy_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            payload_q   <= payload_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.id_ready_o       = id_ready;
    assign bus.ex_valid_o       = ex_valid;
    assign bus.ex_rs1_enable_o  = payload_q.rs1_enable;
    assign bus.ex_rs2_enable_o  = payload_q.rs2_enable;
    assign bus.ex_rs1_addr_o    = payload_q.rs1_addr;
    assign bus.ex_rs2_addr_o    = payload_q.rs2_addr;
    assign bus.ex_rd_addr_o     = payload_q.rd_addr;
    assign bus.ex_rd_we_o       = payload_q.rd_we;
    assign bus.ex_is_load_o     = payload_q.is_load;
    assign bus.ex_alu_2nd_src_o = payload_q.alu_2nd_src;
    assign bus.ex_jal_o         = payload_q.jal;
    assign bus.ex_jalr_o        = payload_q.jalr;
    assign bus.ex_auipc_o       = payload_q.auipc;
    assign bus.ex_pc_o          = payload_q.pc;
    assign bus.ex_imme_o        = payload_q.imme;
    assign bus.fwd_a_o          = fwd_a_q;
    assign bus.fwd_b_o          = fwd_b_q;
    assign stall_cnt_o          = stall_cnt_q;
endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Bench for ex_issue_ctrl: directed scenarios with literal expectations plus an
// instruction-level reference model compared against the DUT every cycle.
module tb_ex_issue_ctrl;
    logic        clk_i;
    logic        rst_ni;
    logic        lsu_wb_valid_i;
    logic [4:0]  lsu_wb_rd_i;
    logic        flush_i;
    logic [31:0] stall_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_on = 0;

    ex_issue_ctrl_if #(.DATA_WIDTH(64), .REG_ADDR_W(5)) bus ();

    ex_issue_ctrl #(.DATA_WIDTH(64), .REG_ADDR_W(5)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .bus            (bus),
        .lsu_wb_valid_i (lsu_wb_valid_i),
        .lsu_wb_rd_i    (lsu_wb_rd_i),
        .flush_i        (flush_i),
        .stall_cnt_o    (stall_cnt_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Reference: the instruction sitting in the slot, the set of destination
    // registers with an outstanding load, and the stall tally.
    typedef struct packed {
        logic        valid;
        logic        rs1_en;
        logic        rs2_en;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        is_load;
        logic        alu2;
        logic        jal;
        logic        jalr;
        logic        auipc;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [1:0]  fwd_a;
        logic [1:0]  fwd_b;
        logic [31:0] pending;
        logic [31:0] stalls;
    } model_t;

    model_t m;

    function automatic bit waits_on(model_t s, logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (lsu_wb_valid_i && lsu_wb_rd_i == r) return 1'b0;
        return s.pending[r];
    endfunction

    function automatic bit model_hazard(model_t s);
        return (bus.rs1_enable_i && waits_on(s, bus.rs1_addr_i))
            || (bus.rs2_enable_i && waits_on(s, bus.rs2_addr_i))
            || (bus.rd_we_i && waits_on(s, bus.rd_addr_i));
    endfunction

    function automatic bit model_ready(model_t s);
        bit room = !s.valid || bus.ex_ready_i;
        return room && !flush_i && !model_hazard(s);
    endfunction

    function automatic logic [1:0] model_fwd(model_t s, logic en, logic [4:0] src);
        if (!en || src == 5'd0) return 2'b00;
        if (s.valid && bus.ex_ready_i && s.rd_we && !s.is_load && s.rd == src) return 2'b01;
        if (lsu_wb_valid_i && lsu_wb_rd_i == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic model_t model_step(model_t s);
        model_t n = s;
        if (bus.id_valid_i && !flush_i && model_hazard(s) && s.stalls != 32'hFFFF_FFFF)
            n.stalls = s.stalls + 1;
        if (lsu_wb_valid_i) n.pending[lsu_wb_rd_i] = 1'b0;
        if (flush_i) begin
            n.valid = 1'b0;
            if (s.valid && s.is_load && s.rd_we) n.pending[s.rd] = 1'b0;
        end else if (bus.id_valid_i && model_ready(s)) begin
            n.valid   = 1'b1;
            n.rs1_en  = bus.rs1_enable_i;
            n.rs2_en  = bus.rs2_enable_i;
            n.rs1     = bus.rs1_addr_i;
            n.rs2     = bus.rs2_addr_i;
            n.rd      = bus.rd_addr_i;
            n.rd_we   = bus.rd_we_i;
            n.is_load = bus.is_load_i;
            n.alu2    = bus.alu_2nd_src_i;
            n.jal     = bus.jal_i;
            n.jalr    = bus.jalr_i;
            n.auipc   = bus.auipc_i;
            n.pc      = bus.pc_i;
            n.imm     = bus.imme_i;
            n.fwd_a   = model_fwd(s, bus.rs1_enable_i, bus.rs1_addr_i);
            n.fwd_b   = model_fwd(s, bus.rs2_enable_i, bus.rs2_addr_i);
            if (bus.is_load_i && bus.rd_we_i) n.pending[bus.rd_addr_i] = 1'b1;
        end else if (!s.valid || bus.ex_ready_i) begin
            n.valid = 1'b0;
        end
        n.pending[0] = 1'b0;
        return n;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) m <= '0;
        else         m <= model_step(m);
    end

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [191:0] dut_fields();
        return {41'd0, bus.ex_rs1_enable_o, bus.ex_rs2_enable_o, bus.ex_rs1_addr_o,
                bus.ex_rs2_addr_o, bus.ex_rd_addr_o, bus.ex_rd_we_o, bus.ex_is_load_o,
                bus.ex_alu_2nd_src_o, bus.ex_jal_o, bus.ex_jalr_o, bus.ex_auipc_o,
                bus.ex_pc_o, bus.ex_imme_o};
    endfunction

    function automatic logic [191:0] model_fields(model_t s);
        return {41'd0, s.rs1_en, s.rs2_en, s.rs1, s.rs2, s.rd, s.rd_we, s.is_load,
                s.alu2, s.jal, s.jalr, s.auipc, s.pc, s.imm};
    endfunction

    always @(negedge clk_i) begin
        if (cmp_on && rst_ni) begin
            check("id_ready", 192'(bus.id_ready_o), 192'(model_ready(m)));
            check("ex_valid", 192'(bus.ex_valid_o), 192'(m.valid));
            check("ex_fields", dut_fields(), model_fields(m));
            check("fwd_a", 192'(bus.fwd_a_o), 192'(m.fwd_a));
            check("fwd_b", 192'(bus.fwd_b_o), 192'(m.fwd_b));
            check("stall_cnt", 192'(stall_cnt_o), 192'(m.stalls));
        end
    end

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
    endtask

    task automatic offer(input bit v, input bit e1, input int r1, input bit e2,
                         input int r2, input int rd, input bit we, input bit ld);
        bus.id_valid_i    = v;
        bus.rs1_enable_i  = e1;
        bus.rs2_enable_i  = e2;
        bus.rs1_addr_i    = 5'(r1);
        bus.rs2_addr_i    = 5'(r2);
        bus.rd_addr_i     = 5'(rd);
        bus.rd_we_i       = we;
        bus.is_load_i     = ld;
        bus.alu_2nd_src_i = rd[0];
        bus.jal_i         = rd[1];
        bus.jalr_i        = r1[0];
        bus.auipc_i       = r2[0];
        bus.pc_i          = 64'h8000_0000 + 64'(rd * 4) + 64'(r1 * 256);
        bus.imme_i        = 64'hF00D_0000_0000_0000 ^ 64'(r2 * 17 + rd);
    endtask

    task automatic idle();
        offer(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni         = 1'b0;
        flush_i        = 1'b0;
        lsu_wb_valid_i = 1'b0;
        lsu_wb_rd_i    = 5'd0;
        bus.ex_ready_i = 1'b1;
        idle();
        tick();
        tick();
        rst_ni = 1'b1;
        cmp_on = 1'b1;
        check("rst_valid", 192'(bus.ex_valid_o), 192'd0);
        check("rst_stall", 192'(stall_cnt_o), 192'd0);
        #1 check("rst_ready", 192'(bus.id_ready_o), 192'd1);

        // add x3,x1,x2 then sub x4,x3,x1
        offer(1, 1, 1, 1, 2, 3, 1, 0);
        tick();
        check("alu_first_rd", 192'(bus.ex_rd_addr_o), 192'd3);
        offer(1, 1, 3, 1, 1, 4, 1, 0);
        tick();
        check("alu_fwd_rd", 192'(bus.ex_rd_addr_o), 192'd4);
        check("alu_fwd_a", 192'(bus.fwd_a_o), 192'd1);
        check("alu_fwd_b", 192'(bus.fwd_b_o), 192'd0);
        idle();
        tick();

        // ld x5 then addi x6,x5: three stall cycles, wakes on writeback
        offer(1, 1, 2, 0, 0, 5, 1, 1);
        tick();
        offer(1, 1, 5, 0, 0, 6, 1, 0);
        #1 check("lu_ready_low", 192'(bus.id_ready_o), 192'd0);
        repeat (3) tick();
        lsu_wb_valid_i = 1'b1;
        lsu_wb_rd_i    = 5'd5;
        #1 check("lu_ready_wb", 192'(bus.id_ready_o), 192'd1);
        tick();
        lsu_wb_valid_i = 1'b0;
        check("lu_rd", 192'(bus.ex_rd_addr_o), 192'd6);
        check("lu_fwd_a", 192'(bus.fwd_a_o), 192'd2);
        check("lu_stalls", 192'(stall_cnt_o), 192'd3);
        idle();
        tick();

        // ld x0 then add x1,x0,x0
        offer(1, 1, 2, 0, 0, 0, 1, 1);
        tick();
        offer(1, 1, 0, 1, 0, 1, 1, 0);
        #1 check("x0_ready", 192'(bus.id_ready_o), 192'd1);
        tick();
        check("x0_rd", 192'(bus.ex_rd_addr_o), 192'd1);
        check("x0_fwd", 192'({bus.fwd_a_o, bus.fwd_b_o}), 192'd0);
        check("x0_stalls", 192'(stall_cnt_o), 192'd3);
        idle();
        tick();

        // flush with ld x7 in the slot
        offer(1, 1, 2, 0, 0, 7, 1, 1);
        tick();
        offer(1, 1, 9, 0, 0, 8, 1, 0);
        flush_i = 1'b1;
        #1 check("fl_ready", 192'(bus.id_ready_o), 192'd0);
        tick();
        flush_i = 1'b0;
        check("fl_valid", 192'(bus.ex_valid_o), 192'd0);
        offer(1, 1, 7, 0, 0, 10, 1, 0);
        #1 check("fl_busy_clr", 192'(bus.id_ready_o), 192'd1);
        tick();
        check("fl_next_rd", 192'(bus.ex_rd_addr_o), 192'd10);
        check("fl_next_fwd", 192'(bus.fwd_a_o), 192'd0);

        // backpressure for four cycles
        bus.ex_ready_i = 1'b0;
        offer(1, 1, 1, 1, 2, 11, 1, 0);
        repeat (4) begin
            #1 check("bp_ready", 192'(bus.id_ready_o), 192'd0);
            tick();
            check("bp_hold_rd", 192'(bus.ex_rd_addr_o), 192'd10);
        end
        check("bp_stalls", 192'(stall_cnt_o), 192'd3);
        bus.ex_ready_i = 1'b1;
        tick();
        check("bp_release_rd", 192'(bus.ex_rd_addr_o), 192'd11);

        // ALU forward beats LSU writeback to the same register
        offer(1, 1, 1, 0, 0, 13, 1, 0);
        tick();
        offer(1, 1, 13, 1, 13, 14, 1, 0);
        lsu_wb_valid_i = 1'b1;
        lsu_wb_rd_i    = 5'd13;
        tick();
        lsu_wb_valid_i = 1'b0;
        check("prio_fwd_a", 192'(bus.fwd_a_o), 192'd1);
        check("prio_fwd_b", 192'(bus.fwd_b_o), 192'd1);

        // WAW on x12, then set-wins when a new ld x12 issues as the old returns
        offer(1, 1, 1, 0, 0, 12, 1, 1);
        tick();
        offer(1, 1, 2, 0, 0, 12, 1, 1);
        #1 check("waw_ready", 192'(bus.id_ready_o), 192'd0);
        tick();
        lsu_wb_valid_i = 1'b1;
        lsu_wb_rd_i    = 5'd12;
        #1 check("waw_wake", 192'(bus.id_ready_o), 192'd1);
        tick();
        lsu_wb_valid_i = 1'b0;
        offer(1, 1, 12, 0, 0, 15, 1, 0);
        #1 check("set_wins", 192'(bus.id_ready_o), 192'd0);
        tick();
        lsu_wb_valid_i = 1'b1;
        tick();
        lsu_wb_valid_i = 1'b0;
        check("sw_rd", 192'(bus.ex_rd_addr_o), 192'd15);
        check("sw_fwd_a", 192'(bus.fwd_a_o), 192'd2);
        check("sw_stalls", 192'(stall_cnt_o), 192'd5);
        idle();
        tick();

        // asynchronous reset with a held load in the slot
        bus.ex_ready_i = 1'b0;
        offer(1, 1, 2, 0, 0, 5, 1, 1);
        tick();
        check("mr_full", 192'(bus.ex_valid_o), 192'd1);
        idle();
        rst_ni = 1'b0;
        #1;
        check("mr_valid", 192'(bus.ex_valid_o), 192'd0);
        check("mr_stalls", 192'(stall_cnt_o), 192'd0);
        check("mr_rd", 192'(bus.ex_rd_addr_o), 192'd0);
        rst_ni = 1'b1;
        bus.ex_ready_i = 1'b1;
        offer(1, 1, 5, 0, 0, 6, 1, 0);
        #1 check("mr_busy_clr", 192'(bus.id_ready_o), 192'd1);
        tick();
        check("mr_issue_rd", 192'(bus.ex_rd_addr_o), 192'd6);

        // mixed traffic over a small register window, checked by the model
        for (int i = 0; i < 80; i++) begin
            offer((i % 3) != 2, (i % 4) != 3, i % 7, (i % 5) != 1, (i * 3) % 8,
                  (i * 5) % 8, (i % 5) != 4, (i % 4) == 0);
            bus.ex_ready_i = (i % 6) != 5;
            lsu_wb_valid_i = (i % 3) == 1;
            lsu_wb_rd_i    = 5'((i * 2) % 8);
            flush_i        = (i % 11) == 10;
            tick();
        end
        flush_i        = 1'b0;
        lsu_wb_valid_i = 1'b0;
        bus.ex_ready_i = 1'b1;
        idle();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
